// File: rtl/stimecmp_unit_pkg.sv
// stimecmp_unit_pkg
//   Shared definitions for the supervisor timer-compare unit.
//   Contents:
//     - tc_state_e        : per-channel RV32 split-write state (IDLE / HI_PEND)
//     - ADR_BASE_DEFAULT  : CSR address of channel 0 low word
//     - ADR_HI_OFFSET     : distance from a low-word address to its high word
//     - CMP_RESET_VALUE   : compare register value after reset (never matches)
//     - window_hit()      : offset-in-window helper used by the address decoder
package stimecmp_unit_pkg;

    localparam logic [11:0] ADR_BASE_DEFAULT = 12'h14D;
    localparam logic [11:0] ADR_HI_OFFSET    = 12'd16;
    localparam int unsigned NCH_MAX          = 8;
    localparam logic [63:0] CMP_RESET_VALUE  = 64'hFFFF_FFFF_FFFF_FFFF;

    typedef enum logic [0:0] {
        TC_IDLE    = 1'b0,
        TC_HI_PEND = 1'b1
    } tc_state_e;

    // True when an address offset (already rebased to the window start)
    // falls inside a window of n consecutive CSRs. Offsets below the window
    // wrap to large values, so a single unsigned compare covers both ends.
    function automatic logic window_hit(input logic [11:0] off, input int unsigned n);
        return (off < 12'(n));
    endfunction

endpackage

// File: rtl/stimecmp_chan.sv
// stimecmp_chan
//   One supervisor timer-compare channel: 64-bit compare register, RV32
//   high-word shadow with its two-state commit FSM, registered match and
//   (optionally) a latched pending bit.
//   Ports:
//     clk, reset_n  : clock, asynchronous active-low reset
//     en            : channel enable (STCE); gates the interrupt output only
//     wr_lo, wr_hi  : decoded write strobes for this channel's low/high CSR
//     wdata         : CSR write data (XLEN bits)
//     mtime         : current time
//     int_ack       : interrupt acknowledge (latched mode only)
//     cmp_o         : committed compare value (for CSR reads)
//     int_o         : timer interrupt
module stimecmp_chan
    import stimecmp_unit_pkg::*;
#(
    parameter int XLEN   = 64,
    parameter bit STICKY = 1'b0
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            en,
    input  logic            wr_lo,
    input  logic            wr_hi,
    input  logic [XLEN-1:0] wdata,
    input  logic [63:0]     mtime,
    input  logic            int_ack,
    output logic [63:0]     cmp_o,
    output logic            int_o
);

    logic [63:0] cmp_q, cmp_d;
    logic [31:0] shadow_q, shadow_d;
    tc_state_e   state_q, state_d;
    logic        match_q, match_d;
    logic        pending_q, pending_d;
    logic        commit_s;
    logic        match_now_s;
    logic [63:0] wdata64_s;

    assign wdata64_s = 64'(wdata);

    // Compare-register write path, including the RV32 high/low commit FSM.
    always_comb begin
        cmp_d    = cmp_q;
        shadow_d = shadow_q;
        state_d  = state_q;
        commit_s = 1'b0;
        if (XLEN == 64) begin
            if (wr_lo) begin
                cmp_d    = wdata64_s;
                commit_s = 1'b1;
            end else begin
                cmp_d    = cmp_q;
            end
        end else begin
            case (state_q)
                TC_IDLE: begin
                    if (wr_hi) begin
                        // High half is held back until the low half arrives.
                        shadow_d = wdata64_s[31:0];
                        state_d  = TC_HI_PEND;
                    end else if (wr_lo) begin
                        cmp_d[31:0] = wdata64_s[31:0];
                        commit_s    = 1'b1;
                    end else begin
                        state_d = TC_IDLE;
                    end
                end
                TC_HI_PEND: begin
                    if (wr_hi) begin
                        shadow_d = wdata64_s[31:0];
                    end else if (wr_lo) begin
                        cmp_d    = {shadow_q, wdata64_s[31:0]};
                        commit_s = 1'b1;
                        state_d  = TC_IDLE;
                    end else begin
                        state_d = TC_HI_PEND;
                    end
                end
                default: begin
                    state_d = TC_IDLE;
                end
            endcase
        end
    end

    // Match and pending next-state. In a commit cycle the old compare value
    // must not produce a match, so the comparison is suppressed until the
    // new value is in cmp_q.
    always_comb begin
        match_now_s = (mtime >= cmp_q) & ~commit_s;
        match_d     = match_now_s;
        if (match_now_s) begin
            pending_d = 1'b1;
        end else if (int_ack | commit_s) begin
            pending_d = 1'b0;
        end else begin
            pending_d = pending_q;
        end
    end

    // Channel state registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cmp_q     <= CMP_RESET_VALUE;
            shadow_q  <= 32'h0000_0000;
            state_q   <= TC_IDLE;
            match_q   <= 1'b0;
            pending_q <= 1'b0;
        end else begin
            cmp_q     <= cmp_d;
            shadow_q  <= shadow_d;
            state_q   <= state_d;
            match_q   <= match_d;
            pending_q <= pending_d;
        end
    end

    assign cmp_o = cmp_q;
    assign int_o = (STICKY ? pending_q : match_q) & en;

endmodule

// File: rtl/stimecmp_unit.sv
// stimecmp_unit
//   Multi-channel supervisor timer-compare CSR block. Decodes the CSR
//   address window, steers writes to the channels, muxes read data and
//   collects the per-channel interrupts.
//   Ports:
//     clk, reset_n    : clock, asynchronous active-low reset
//     CSRWriteM       : CSR write strobe
//     CSRAdrM         : CSR address
//     CSRWriteValM    : CSR write data
//     STCE            : menvcfg.STCE; when low the whole block is inert
//     MTIME_CLINT     : current time
//     IntAckM         : per-channel interrupt acknowledge (latched mode)
//     CSRReadValM     : combinational read data
//     IllegalAccessM  : unmapped address or access while disabled
//     STimerIntM      : per-channel timer interrupt
module stimecmp_unit
    import stimecmp_unit_pkg::*;
#(
    parameter int          XLEN     = 64,
    parameter int          NCH      = 2,
    parameter logic [11:0] ADR_BASE = ADR_BASE_DEFAULT,
    parameter bit          STICKY   = 1'b0
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            CSRWriteM,
    input  logic [11:0]     CSRAdrM,
    input  logic [XLEN-1:0] CSRWriteValM,
    input  logic            STCE,
    input  logic [63:0]     MTIME_CLINT,
    input  logic [NCH-1:0]  IntAckM,
    output logic [XLEN-1:0] CSRReadValM,
    output logic            IllegalAccessM,
    output logic [NCH-1:0]  STimerIntM
);

    logic [11:0]    off_lo_s;
    logic [11:0]    off_hi_s;
    logic           lo_hit_s;
    logic           hi_hit_s;
    logic [2:0]     chan_s;
    logic           access_ok_s;
    logic [NCH-1:0] wr_lo_s;
    logic [NCH-1:0] wr_hi_s;
    logic [63:0]    cmp_s [NCH];
    logic [63:0]    sel_cmp_s;
    logic [63:0]    rd64_s;

    // Address decode: low window always exists, high window only on RV32.
    always_comb begin
        off_lo_s = CSRAdrM - ADR_BASE;
        off_hi_s = CSRAdrM - ADR_BASE - ADR_HI_OFFSET;
        lo_hit_s = window_hit(off_lo_s, NCH);
        if (XLEN == 32) begin
            hi_hit_s = window_hit(off_hi_s, NCH);
        end else begin
            hi_hit_s = 1'b0;
        end
        if (lo_hit_s) begin
            chan_s = off_lo_s[2:0];
        end else begin
            chan_s = off_hi_s[2:0];
        end
        access_ok_s = STCE & (lo_hit_s | hi_hit_s);
    end

    // Per-channel write strobes; nothing reaches a channel while disabled.
    always_comb begin
        wr_lo_s = '0;
        wr_hi_s = '0;
        for (int i = 0; i < NCH; i++) begin
            if (chan_s == 3'(i)) begin
                wr_lo_s[i] = CSRWriteM & STCE & lo_hit_s;
                wr_hi_s[i] = CSRWriteM & STCE & hi_hit_s;
            end else begin
                wr_lo_s[i] = 1'b0;
                wr_hi_s[i] = 1'b0;
            end
        end
    end

    // Read mux: select the addressed channel, then the requested half.
    always_comb begin
        sel_cmp_s = 64'd0;
        for (int i = 0; i < NCH; i++) begin
            if (chan_s == 3'(i)) begin
                sel_cmp_s = cmp_s[i];
            end else begin
                sel_cmp_s = sel_cmp_s;
            end
        end
        if (access_ok_s && lo_hit_s) begin
            if (XLEN == 64) begin
                rd64_s = sel_cmp_s;
            end else begin
                rd64_s = {32'h0000_0000, sel_cmp_s[31:0]};
            end
        end else if (access_ok_s && hi_hit_s) begin
            rd64_s = {32'h0000_0000, sel_cmp_s[63:32]};
        end else begin
            rd64_s = 64'd0;
        end
    end

    assign CSRReadValM    = rd64_s[XLEN-1:0];
    assign IllegalAccessM = ~access_ok_s;

    for (genvar i = 0; i < NCH; i++) begin : g_chan
        stimecmp_chan #(
            .XLEN   (XLEN),
            .STICKY (STICKY)
        ) u_chan (
            .clk     (clk),
            .reset_n (reset_n),
            .en      (STCE),
            .wr_lo   (wr_lo_s[i]),
            .wr_hi   (wr_hi_s[i]),
            .wdata   (CSRWriteValM),
            .mtime   (MTIME_CLINT),
            .int_ack (IntAckM[i]),
            .cmp_o   (cmp_s[i]),
            .int_o   (STimerIntM[i])
        );
    end

endmodule
